vme_strobe_master: RTL and testbench
====================================

// Module: vme_strobe_master
// PURPOSE
//  Upstream driver for the register-block slave port (VMEAddr/VMEWrData/VMERdMem/VMEWrMem in,
//  VMERdData/VMERdDone/VMEWrDone out). Accepts single transactions over a valid/ready request
//  channel, issues a one-cycle read or write strobe, waits for the matching Done with a timeout,
//  and returns data plus an error flag over a valid/ready response channel. One transaction in flight.
// PARAMETERS
//  ADDR_WIDTH    4        slave word-address width; address bus is [ADDR_WIDTH:1]
//  DATA_WIDTH    16       data bus width
//  TIMEOUT       255      cycles in WAIT without Done before the transaction is failed (>=1)
//  BUS_ERR_DATA  16'hDEAD rsp_data_o value returned on a timed-out read
// PORTS
//  Clk           in   1           single clock; all logic on the rising edge
//  RstN          in   1           asynchronous, active-low reset
//  req_valid_i   in   1           request valid
//  req_ready_o   out  1           request accepted when valid & ready
//  req_write_i   in   1           1 = write, 0 = read
//  req_addr_i    in   ADDR_WIDTH  word address [ADDR_WIDTH:1]
//  req_data_i    in   DATA_WIDTH  write data
//  rsp_valid_o   out  1           response valid
//  rsp_ready_i   in   1           response consumed when valid & ready
//  rsp_data_o    out  DATA_WIDTH  read data (0 for writes)
//  rsp_err_o     out  1           1 = timeout
//  VMEAddr       out  ADDR_WIDTH  slave address [ADDR_WIDTH:1]
//  VMEWrData     out  DATA_WIDTH  slave write data
//  VMERdMem      out  1           read strobe, one cycle
//  VMEWrMem      out  1           write strobe, one cycle
//  VMERdData     in   DATA_WIDTH  slave read data, valid in the VMERdDone cycle
//  VMERdDone     in   1           read acknowledge
//  VMEWrDone     in   1           write acknowledge
//  busy_o        out  1           1 in every state except IDLE
// BEHAVIOUR
//  Reset (async, RstN=0): state=IDLE, counter=0; all outputs 0 incl. VMEAddr, VMEWrData, rsp_data_o.
//   Strobes drop immediately; an in-flight transaction is discarded and returns no response.
//  All outputs are registered or decoded from the state register only; no combinational
//   input-to-output paths.
//  FSM IDLE -> STROBE -> WAIT -> RESP -> IDLE.
//  IDLE: req_ready_o=1. On req_valid_i: latch dir/addr/data, drive VMEAddr/VMEWrData,
//   clear counter, go to STROBE.
//  STROBE (1 cycle): VMEWrMem=dir, VMERdMem=~dir. Next state is WAIT.
//  WAIT: increment counter each cycle. A matching Done sampled in STROBE or WAIT completes the
//   transaction (VMERdDone for reads, VMEWrDone for writes):
//   - read: rsp_data_o <= VMERdData
//   - write: rsp_data_o <= 0
//   - rsp_err_o <= 0; go to RESP.
//  Timeout: counter==TIMEOUT in WAIT with no matching Done -> rsp_err_o <= 1,
//   rsp_data_o <= BUS_ERR_DATA (read) or 0 (write); go to RESP.
//   A Done in that same cycle wins: no error.
//  Done of the wrong direction, or any Done in IDLE/RESP, is ignored.
//  VMEAddr/VMEWrData are held stable from STROBE until the next request is accepted.
//  RESP: rsp_valid_o=1; data and err held until rsp_ready_i=1, then go to IDLE.
//   Not ready while RESP is pending.
//  Latency, zero-wait slave: request accept -> strobe 1 cycle later;
//   slave Done 1 cycle after strobe -> rsp_valid_o 2 cycles after strobe.
//   Minimum 4 cycles per transaction.
//  Counter width is clog2(TIMEOUT+1); saturates and never wraps.
// TESTING
//  Read addr 4'h0, Done 1 cycle after strobe, VMERdData=16'h0001
//   -> one VMERdMem pulse, rsp_data_o=16'h0001, rsp_err_o=0.
//  Write addr 4'hB, data 16'h00A5, VMEWrDone 1 cycle after strobe -> one VMEWrMem pulse,
//   VMEWrData=16'h00A5 stable; rsp_err_o=0, rsp_data_o=0.
//  Read with no Done, TIMEOUT=8 -> rsp_valid_o 9 cycles after strobe,
//   rsp_err_o=1, rsp_data_o=16'hDEAD.
//  Done exactly at counter==TIMEOUT -> rsp_err_o=0, captured data returned.
//   Wrong-direction Done -> ignored, transaction still times out.
//  rsp_ready_i held 0 for 5 cycles -> response held stable, req_ready_o=0;
//   back-to-back requests serviced in order.
//  RstN pulsed low during WAIT -> outputs 0 asynchronously, no response,
//   IDLE with req_ready_o=1 after release.

Source files
------------

// File: rtl/vme_strobe_master.sv
// vme_strobe_master
//   Drives the register-block slave port one transaction at a time. A request
//   accepted on the req_* channel becomes a single-cycle read or write strobe;
//   the master then waits for the Done of the same direction, giving up after
//   TIMEOUT cycles, and returns data plus an error flag on the rsp_* channel.
//
// Ports
//   Clk, RstN                 clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_write_i               1 = write, 0 = read
//   req_addr_i, req_data_i    word address [ADDR_WIDTH:1], write data
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_data_o, rsp_err_o     read data (0 for writes), 1 = timed out
//   VMEAddr, VMEWrData        slave address / write data, held from strobe on
//   VMERdMem, VMEWrMem        one-cycle read / write strobes
//   VMERdData, VMERdDone      slave read data and read acknowledge
//   VMEWrDone                 slave write acknowledge
//   busy_o                    high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | ready for a request
// STROBE | strobe asserted for one cycle
// WAIT   | waiting for the matching Done, counting toward TIMEOUT
// RESP   | response presented until consumed
module vme_strobe_master #(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0] BUS_ERR_DATA = 16'hDEAD
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH:1]   req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH:1]   VMEAddr,
  output logic [DATA_WIDTH-1:0] VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [DATA_WIDTH-1:0] VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  output logic                  busy_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q;
  logic                  dir_q;
  logic [CW-1:0]         cnt_q;
  logic                  ready_q;
  logic                  rd_mem_q;
  logic                  wr_mem_q;
  logic [ADDR_WIDTH:1]   addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  done_match;

  // Only the Done matching the latched direction can complete a transaction.
  assign done_match = dir_q ? VMEWrDone : VMERdDone;

  // The counter runs from the strobe cycle, so in WAIT it equals the number
  // of cycles elapsed since the strobe. It saturates rather than wraps.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_mem_q   <= 1'b0;
      wr_mem_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && ready_q) begin
            dir_q    <= req_write_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_data_i;
            cnt_q    <= '0;
            wr_mem_q <= req_write_i;
            rd_mem_q <= ~req_write_i;
            ready_q  <= 1'b0;
            state_q  <= STROBE;
          end else begin
            // ready rises one cycle after reset release
            ready_q <= 1'b1;
          end
        end
        STROBE, WAIT: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (done_match) begin
            rsp_data_q <= dir_q ? '0 : VMERdData;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end else if (state_q == WAIT && cnt_q == CNT_TO) begin
            rsp_data_q <= dir_q ? '0 : BUS_ERR_DATA;
            rsp_err_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign VMEAddr     = addr_q;
  assign VMEWrData   = wdata_q;
  assign VMERdMem    = rd_mem_q;
  assign VMEWrMem    = wr_mem_q;

endmodule

// File: tb/tb_vme_strobe_master.sv
module tb_vme_strobe_master;

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [4:1]  req_addr_i = '0;
  logic [15:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic [4:1]  VMEAddr;
  logic [15:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic [15:0] VMERdData = '0;
  logic        VMERdDone = 1'b0;
  logic        VMEWrDone = 1'b0;
  logic        busy_o;

  vme_strobe_master #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .TIMEOUT(8), .BUS_ERR_DATA(16'hDEAD)
  ) dut (
    .Clk(Clk), .RstN(RstN),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .busy_o(busy_o)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;

  always @(posedge Clk) begin
    if (VMERdMem) rd_pulses++;
    if (VMEWrMem) wr_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One transaction. Strobe cycle is k=0; Done is driven during cycle done_at
  // (-1 = never). wrong_dir drives only the opposite Done every cycle.
  task automatic run_txn(input string tag, input logic wr, input logic [3:0] addr,
                         input logic [15:0] wdata, input int done_at, input logic wrong_dir,
                         input logic [15:0] rdata, input int hold, input int exp_lat,
                         input logic [15:0] exp_data, input logic exp_err);
    int rd0, wr0, lat;
    logic bad, bad_hold;
    @(negedge Clk);
    chk({tag, ".req_ready"}, req_ready_o, 1);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_data_i = wdata;
    rd0 = rd_pulses; wr0 = wr_pulses;
    @(negedge Clk);
    req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    chk({tag, ".strobe"}, {VMEWrMem, VMERdMem, busy_o}, {wr, ~wr, 1'b1});
    chk({tag, ".addr"}, VMEAddr, addr);
    lat = -1; bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid_o) begin lat = k; break; end
      if (VMEAddr !== addr || (wr && VMEWrData !== wdata) || req_ready_o) bad = 1'b1;
      if (k > 0 && (VMERdMem || VMEWrMem)) bad = 1'b1;
      if (wrong_dir) begin
        VMERdDone = wr; VMEWrDone = ~wr;
      end else begin
        VMERdDone = ~wr && (k == done_at);
        VMEWrDone = wr && (k == done_at);
      end
      VMERdData = (k == done_at) ? rdata : 16'h5A5A;
      @(negedge Clk);
    end
    VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdData = '0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".stable_wait"}, bad, 0);
    chk({tag, ".rsp_data"}, rsp_data_o, exp_data);
    chk({tag, ".rsp_err"}, rsp_err_o, exp_err);
    if (wr) chk({tag, ".wrdata"}, VMEWrData, wdata);
    if (hold > 0) begin
      bad_hold = 1'b0;
      for (int h = 0; h < hold; h++) begin
        VMERdDone = 1'b1; VMEWrDone = 1'b1; VMERdData = 16'hFFFF;
        req_valid_i = 1'b1; req_addr_i = ~addr;
        @(negedge Clk);
        if (!rsp_valid_o || rsp_data_o !== exp_data || rsp_err_o !== exp_err ||
            req_ready_o || VMERdMem || VMEWrMem || VMEAddr !== addr) bad_hold = 1'b1;
      end
      VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdData = '0;
      req_valid_i = 1'b0; req_addr_i = '0;
      chk({tag, ".hold"}, bad_hold, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge Clk);
    rsp_ready_i = 1'b0;
    chk({tag, ".done_idle"}, {rsp_valid_o, req_ready_o, busy_o}, 3'b010);
    chk({tag, ".pulses"}, {rd_pulses - rd0, wr_pulses - wr0}, {(wr ? 32'd0 : 32'd1), (wr ? 32'd1 : 32'd0)});
  endtask

  initial begin
    #12;
    chk("reset_outputs",
        {VMEAddr, VMEWrData[7:0], VMERdMem, VMEWrMem, busy_o, req_ready_o, rsp_valid_o, rsp_err_o},
        32'd0);
    chk("reset_rsp_data", rsp_data_o, 0);
    @(negedge Clk);
    RstN = 1'b1;

    //      tag       wr    addr   wdata     done wrong rdata     hold lat data      err
    run_txn("rd0",    1'b0, 4'h0, 16'h0000,  1, 1'b0, 16'h0001, 0, 2, 16'h0001, 1'b0);
    run_txn("wrB",    1'b1, 4'hB, 16'h00A5,  1, 1'b0, 16'h0000, 0, 2, 16'h0000, 1'b0);
    run_txn("rd_to",  1'b0, 4'h3, 16'h0000, -1, 1'b0, 16'h0000, 0, 9, 16'hDEAD, 1'b1);
    run_txn("rd_edge",1'b0, 4'h5, 16'h0000,  8, 1'b0, 16'h1234, 0, 9, 16'h1234, 1'b0);
    run_txn("wr_wdir",1'b1, 4'h6, 16'hBEEF, -1, 1'b1, 16'h0000, 0, 9, 16'h0000, 1'b1);
    run_txn("rd_wdir",1'b0, 4'h2, 16'h0000, -1, 1'b1, 16'h0000, 0, 9, 16'hDEAD, 1'b1);
    run_txn("rd_strb",1'b0, 4'h9, 16'h0000,  0, 1'b0, 16'h0C0C, 0, 1, 16'h0C0C, 1'b0);
    run_txn("wr_hold",1'b1, 4'hF, 16'h5555,  3, 1'b0, 16'h0000, 5, 4, 16'h0000, 1'b0);
    run_txn("rd_hold",1'b0, 4'hA, 16'h0000,  2, 1'b0, 16'h7777, 5, 3, 16'h7777, 1'b0);

    // Reset during WAIT: everything clears at once, no response afterwards.
    @(negedge Clk);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 4'h7;
    @(negedge Clk);
    req_valid_i = 1'b0; req_addr_i = '0;
    @(negedge Clk);
    @(negedge Clk);
    chk("pre_reset_busy", {busy_o, VMEAddr}, {1'b1, 4'h7});
    #1 RstN = 1'b0;
    #1;
    chk("async_reset",
        {VMEAddr, VMERdMem, VMEWrMem, busy_o, req_ready_o, rsp_valid_o, rsp_err_o}, 32'd0);
    chk("async_reset_data", {VMEWrData, rsp_data_o}, 32'd0);
    @(negedge Clk);
    RstN = 1'b1;
    @(negedge Clk);
    chk("post_reset_idle", {req_ready_o, busy_o, rsp_valid_o}, 3'b100);
    @(negedge Clk);
    chk("post_reset_no_rsp", {req_ready_o, busy_o, rsp_valid_o}, 3'b100);
    run_txn("wr_post",1'b1, 4'h4, 16'hC3C3,  1, 1'b0, 16'h0000, 0, 2, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
